operand_arbiter: RTL and testbench

OPERAND_ARBITER -- requirements
Module: operand_arbiter

---
 rtl/operand_arbiter_pkg.sv | 20 ++
 rtl/operand_arbiter_mux.sv | 13 +
 rtl/operand_arbiter.sv | 84 ++++++++
 tb/tb_operand_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/operand_arbiter_pkg.sv
// Shared definitions for the operand arbiter: FSM state encoding, source codes
// and the two-requester winner rule.
package operand_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Under contention the source not granted most recently wins.
  function automatic logic pick_src(input logic req_a, input logic req_b,
                                    input logic last_src);
    if (req_a && req_b) return ~last_src;
    return req_b ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/operand_arbiter_mux.sv
// Two-input, SIZE-bit operand multiplexer (i_sel=0 selects i_d0).
module operand_arbiter_mux #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] i_d0,
  input  logic [SIZE-1:0] i_d1,
  input  logic            i_sel,
  output logic [SIZE-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/operand_arbiter.sv
// Two-requester operand arbiter with a one-entry registered output stage and
// round-robin tie-breaking between requesters A and B.
module operand_arbiter
  import operand_arbiter_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_a,
  input  logic [SIZE-1:0] data_a,
  output logic            gnt_a,
  input  logic            req_b,
  input  logic [SIZE-1:0] data_b,
  output logic            gnt_b,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready
);

  state_t          r_state;
  state_t          w_next_state;
  logic [SIZE-1:0] r_out_data;
  logic            r_out_src;
  logic            r_last_src;
  logic            w_slot;
  logic            w_grant;
  logic            w_win;
  logic [SIZE-1:0] w_sel_data;

  assign w_win = pick_src(req_a, req_b, r_last_src);

  operand_arbiter_mux #(
    .SIZE (SIZE)
  ) u_mux (
    .i_d0  (data_a),
    .i_d1  (data_b),
    .i_sel (w_win),
    .o_y   (w_sel_data)
  );

  // A slot opens when the output stage is empty or is being drained this cycle.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    w_slot       = (r_state == IDLE) || out_ready;
    if (w_slot) begin
      if (req_a || req_b) begin
        w_grant      = 1'b1;
        w_next_state = HOLD;
      end else begin
        w_next_state = IDLE;
      end
    end
    if (!rst && w_grant) begin
      gnt_a = (w_win == SRC_A);
      gnt_b = (w_win == SRC_B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_out_src  <= SRC_A;
      r_last_src <= SRC_B;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_out_data <= w_sel_data;
        r_out_src  <= w_win;
        r_last_src <= w_win;
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_operand_arbiter.sv
// Directed and randomized bench for operand_arbiter against a transaction-level
// model with an in-order scoreboard of granted operands.
module tb_operand_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        out_ready = 1'b0;
  logic        gnt_a, gnt_b, out_valid, out_src;
  logic [31:0] out_data;

  operand_arbiter #(.SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int cyc = 0;
  logic log_en = 1'b0;

  // Model: one output register plus the round-robin history bit.
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_src = 1'b0;
  logic        m_last = 1'b1;
  logic [31:0] sb_q[$];

  logic        o_ga, o_gb, o_v, o_src;
  logic [31:0] o_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic a, input logic [31:0] da, input logic b,
                       input logic [31:0] db, input logic rdy, input logic rs);
    logic slot, eg_a, eg_b, win;
    req_a = a; data_a = da; req_b = b; data_b = db; out_ready = rdy; rst = rs;
    @(negedge clk);
    o_ga = gnt_a; o_gb = gnt_b; o_v = out_valid; o_src = out_src; o_data = out_data;
    slot = !m_valid || rdy;
    eg_a = 1'b0; eg_b = 1'b0; win = 1'b0;
    if (!rs && slot && (a || b)) begin
      win  = (a && b) ? !m_last : b;
      eg_a = !win;
      eg_b = win;
    end
    chk("gnt_a", gnt_a, eg_a);
    chk("gnt_b", gnt_b, eg_b);
    chk("gnt_excl", gnt_a & gnt_b, 1'b0);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
    end
    if (!rs && out_valid === 1'b1 && rdy) begin
      if (sb_q.size() > 0) chk("sb_order", out_data, sb_q.pop_front());
      else chk("sb_extra", out_valid, 1'b0);
    end
    if (log_en)
      $display("csv,%0d,%0b,%08h,%0b,%08h,%0b,%0b,%0b,%0b,%08h,%0b",
               cyc, a, da, b, db, rdy, gnt_a, gnt_b, out_valid, out_data, out_src);
    if (rs) begin
      m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
      sb_q.delete();
    end else if (eg_a || eg_b) begin
      m_valid = 1'b1;
      m_data  = win ? db : da;
      m_src   = win;
      m_last  = win;
      sb_q.push_back(m_data);
    end else if (slot) begin
      m_valid = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ra, rb, rr, pend_a, pend_b;
    logic [31:0] da, db;
    #1;
    // Reset and single capture from A
    cycle(0, '0, 0, '0, 1, 1);
    cycle(0, '0, 0, '0, 1, 1);
    chk("rst_valid", o_v, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_src", o_src, 1'b0);
    cycle(1, 32'h3F800000, 0, '0, 1, 0);
    chk("s1_gnt_a", o_ga, 1'b1);
    chk("s1_gnt_b", o_gb, 1'b0);
    cycle(0, '0, 0, '0, 0, 0);
    chk("s1_valid", o_v, 1'b1);
    chk("s1_data", o_data, 32'h3F800000);
    chk("s1_src", o_src, 1'b0);
    cycle(0, '0, 0, '0, 1, 0);

    // Continuous contention alternates starting with A
    cycle(0, '0, 0, '0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 32'hA000_0000 + k, 1, 32'hB000_0000 + k, 1, 0);
      chk("s2_gnt_a", o_ga, (k % 2 == 0));
      chk("s2_gnt_b", o_gb, (k % 2 == 1));
      if (k > 0) chk("s2_src", o_src, ((k - 1) % 2));
    end

    // Stall with A waiting behind a B operand
    cycle(0, '0, 1, 32'hC0000000, 1, 0);
    chk("s3_gnt_b", o_gb, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 32'h1234_5678, 0, '0, 0, 0);
      chk("s3_hold_data", o_data, 32'hC0000000);
      chk("s3_hold_gnt_a", o_ga, 1'b0);
    end
    cycle(1, 32'h1234_5678, 0, '0, 1, 0);
    chk("s3_release_gnt_a", o_ga, 1'b1);

    // Reset discards the pending operand; A wins the next contention
    cycle(0, '0, 0, '0, 0, 1);
    cycle(1, 32'h0F0F_0F0F, 1, 32'hF0F0_F0F0, 1, 0);
    chk("s4_valid", o_v, 1'b0);
    chk("s4_data", o_data, 32'h0);
    chk("s4_gnt_a", o_ga, 1'b1);
    cycle(0, '0, 0, '0, 1, 0);

    // Idle with random out_ready
    for (int k = 0; k < 20; k++) begin
      cycle(0, $urandom, 0, $urandom, 1'($urandom_range(0, 1)), 0);
      chk("s5_valid", o_v, 1'b0);
      chk("s5_gnt", {o_ga, o_gb}, 2'b00);
    end

    // Randomized traffic; data held stable while a request waits
    log_en = 1'b1;
    $display("csv,cycle,req_a,data_a,req_b,data_b,out_ready,gnt_a,gnt_b,out_valid,out_data,out_src");
    pend_a = 1'b0; pend_b = 1'b0; da = '0; db = '0;
    for (int k = 0; k < 100; k++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      if (!pend_a) da = $urandom;
      if (!pend_b) db = $urandom;
      cycle(ra, da, rb, db, rr, 0);
      pend_a = ra && !o_ga;
      pend_b = rb && !o_gb;
    end
    log_en = 1'b0;
    chk("sb_residual", sb_q.size(), m_valid ? 1 : 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
